// File: rtl/fir_decim_mac_pkg.sv
// Shared types and constants for the time-multiplexed decimating FIR (package fir_pkg).
package fir_pkg;

    localparam int DEF_INPUT_WIDTH = 16;
    localparam int DEF_COEFF_WIDTH = 8;
    localparam int DEF_NUM_TAPS    = 37;

    typedef enum logic [1:0] {IDLE, MAC, FLUSH, DONE} fir_state_t;

    typedef logic signed [DEF_COEFF_WIDTH-1:0] coeff_arr_t [DEF_NUM_TAPS];

    // Symmetric 37-tap lowpass; DC gain 515.
    localparam coeff_arr_t DEF_COEFFS = '{
        8'sd8,    8'sd6,    8'sd0,   -8'sd7,  -8'sd10,  -8'sd8,    8'sd0,   8'sd10,
        8'sd14,   8'sd11,   8'sd0,  -8'sd15,  -8'sd22, -8'sd18,    8'sd0,   8'sd30,
        8'sd75,   8'sd120,  8'sd127, 8'sd120,  8'sd75,   8'sd30,   8'sd0,  -8'sd18,
       -8'sd22,  -8'sd15,   8'sd0,   8'sd11,   8'sd14,   8'sd10,   8'sd0,  -8'sd8,
       -8'sd10,  -8'sd7,    8'sd0,   8'sd6,    8'sd8
    };

    function automatic int calcAccWidth(input coeff_arr_t c, input int in_width);
        int s;
        s = 0;
        for (int i = 0; i < DEF_NUM_TAPS; i++) begin
            s += (c[i] < 0) ? -int'(c[i]) : int'(c[i]);
        end
        return $clog2(s) + in_width;
    endfunction

endpackage

// File: rtl/fir_sample_ram.sv
// Circular sample buffer: one write port and one read port with a registered (1-cycle) read.
module fir_sample_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 37,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_decim_mac.sv
// Decimating FIR with a single MAC that walks the sample history once per DECIM accepts.
// Optional FIR_DECIM_ROUND_EN: round-half-up with positive saturation in the output stage.
module fir_decim_mac
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int COEFF_WIDTH  = DEF_COEFF_WIDTH,
    parameter int NUM_TAPS     = DEF_NUM_TAPS,
    parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = DEF_COEFFS,
    parameter int DECIM        = 4,
    parameter int ACC_WIDTH    = calcAccWidth(DEF_COEFFS, DEF_INPUT_WIDTH),
    parameter int OUTPUT_WIDTH = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [INPUT_WIDTH-1:0]  din,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [OUTPUT_WIDTH-1:0] dout
);

    localparam int PTR_W  = $clog2(NUM_TAPS);
    localparam int FILL_W = $clog2(NUM_TAPS + 1);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_TAPS - 1);

    fir_state_t state_q, state_d;
    logic ready_q, ready_d, issue, flush_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, tap_q, s1_tap_q;
    logic [PH_W-1:0]   phase_q;
    logic [FILL_W-1:0] fill_q;
    logic s1_vld_q, s1_first_q, s1_last_q, s1_use_q;
    logic s2_vld_q, s2_first_q, s2_last_q;
    logic [INPUT_WIDTH-1:0]        rd_data;
    logic signed [PROD_W-1:0]      prod_q, prod_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [OUTPUT_WIDTH-1:0]       dout_q, dout_d;

    wire accept  = valid_in && ready_q;
    wire trigger = accept && (phase_q == PH_W'(DECIM - 1));

    fir_sample_ram #(.WIDTH(INPUT_WIDTH), .DEPTH(NUM_TAPS), .ADDR_W(PTR_W)) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = MAC;
            MAC:     if (tap_q == LAST_IDX) state_d = FLUSH;
            FLUSH:   if (flush_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready is registered from the next state so it is low throughout reset.
    always_comb begin
        issue     = (state_q == MAC);
        valid_out = (state_q == DONE);
        ready_d   = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            phase_q  <= '0;
            fill_q   <= '0;
            tap_q    <= '0;
            rd_ptr_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            if (accept) begin
                wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
                phase_q  <= trigger ? '0 : phase_q + PH_W'(1);
                if (fill_q != FILL_W'(NUM_TAPS)) fill_q <= fill_q + FILL_W'(1);
            end
            // Tap 0 reads the slot being written by the triggering accept.
            if (state_q == IDLE) begin
                tap_q    <= '0;
                rd_ptr_q <= wr_ptr_q;
            end else if (issue) begin
                tap_q    <= tap_q + PTR_W'(1);
                rd_ptr_q <= (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - PTR_W'(1);
            end
            flush_q <= (state_q == FLUSH) && !flush_q;
        end
    end

    always_comb begin
        prod_d = '0;
        if (s1_use_q) prod_d = PROD_W'($signed(rd_data)) * PROD_W'(COEFFS[s1_tap_q]);
    end

    assign acc_d = s2_first_q ? ACC_WIDTH'(prod_q) : acc_q + ACC_WIDTH'(prod_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_use_q   <= 1'b0;
            s1_tap_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            dout_q     <= '0;
        end else begin
            s1_vld_q   <= issue;
            s1_first_q <= (tap_q == '0);
            s1_last_q  <= (tap_q == LAST_IDX);
            s1_use_q   <= (FILL_W'(tap_q) < fill_q);
            s1_tap_q   <= tap_q;
            s2_vld_q   <= s1_vld_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            prod_q     <= prod_d;
            if (s2_vld_q) acc_q <= acc_d;
            if (s2_vld_q && s2_last_q) dout_q <= dout_d;
        end
    end

    generate
        if (ACC_WIDTH == OUTPUT_WIDTH) begin : g_out_full
            assign dout_d = acc_d;
        end else begin : g_out_narrow
`ifdef FIR_DECIM_ROUND_EN
            localparam logic [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (ACC_WIDTH - OUTPUT_WIDTH - 1);
            logic [ACC_WIDTH-1:0] rnd;
            logic unused_rnd_lsbs;
            assign rnd = acc_d + HALF;
            assign unused_rnd_lsbs = ^rnd[ACC_WIDTH-OUTPUT_WIDTH-1:0];
            // A non-negative acc that turns negative after rounding has overflowed.
            assign dout_d = (!acc_d[ACC_WIDTH-1] && rnd[ACC_WIDTH-1]) ?
                            {1'b0, {(OUTPUT_WIDTH-1){1'b1}}} : rnd[ACC_WIDTH-1 -: OUTPUT_WIDTH];
`else
            logic unused_acc_lsbs;
            assign unused_acc_lsbs = ^acc_d[ACC_WIDTH-OUTPUT_WIDTH-1:0];
            assign dout_d = acc_d[ACC_WIDTH-1 -: OUTPUT_WIDTH];
`endif
        end
    endgenerate

    assign ready_in = ready_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_fir_decim_mac.sv
// Directed bench for fir_decim_mac: impulse, step with backpressure, reset abort, wrap, rounding.
module tb_fir_decim_mac;

    localparam int NT = 37;
    localparam int TBC [NT] = '{8, 6, 0, -7, -10, -8, 0, 10, 14, 11, 0, -15, -22, -18, 0, 30,
                                75, 120, 127, 120, 75, 30, 0, -18, -22, -15, 0, 11, 14, 10, 0,
                                -8, -10, -7, 0, 6, 8};
    localparam logic signed [7:0] RC [NT] = '{0: 8'sd6, default: 8'sd0};
`ifdef FIR_DECIM_ROUND_EN
    localparam longint ROUND_EXP = 2;
`else
    localparam longint ROUND_EXP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst4;
    logic valid1, valid4, validr;
    logic [15:0] din1, din4, dinr;
    logic ready1, ready4, readyr, vo1, vo4, vor;
    logic [25:0] dout1, dout4, doutr;

    fir_decim_mac #(.DECIM(1)) u1 (
        .clk(clk), .rst(rst1), .valid_in(valid1), .din(din1),
        .ready_in(ready1), .valid_out(vo1), .dout(dout1));
    fir_decim_mac #(.DECIM(4)) u4 (
        .clk(clk), .rst(rst4), .valid_in(valid4), .din(din4),
        .ready_in(ready4), .valid_out(vo4), .dout(dout4));
    fir_decim_mac #(.COEFFS(RC), .DECIM(1), .ACC_WIDTH(28), .OUTPUT_WIDTH(26)) ur (
        .clk(clk), .rst(rst4), .valid_in(validr), .din(dinr),
        .ready_in(readyr), .valid_out(vor), .dout(doutr));

    int n_cmp = 0;
    int n_bad = 0;
    longint hist1 [$];
    longint hist4 [$];
    longint exp4, last4;
    int n, due, ph, outs, seen;
    logic exp_rdy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_out(input longint h [$]);
        longint s = 0;
        for (int k = 0; k < NT && k < h.size(); k++) s += TBC[k] * h[h.size()-1-k];
        return s;
    endfunction

    // One triggering accept on u1 (DECIM=1), then latency, pulse and dout checks.
    task automatic send1(input logic [15:0] s, input string tag);
        longint e;
        int w;
        w = 0;
        while (!ready1 && w < 100) begin tick(); w++; end
        chk({tag, " ready"}, ready1, 1);
        valid1 = 1'b1;
        din1 = s;
        tick();
        valid1 = 1'b0;
        hist1.push_back(longint'($signed(s)));
        e = ref_out(hist1);
        chk({tag, " busy"}, ready1, 0);
        w = 0;
        while (!vo1 && w < 100) begin tick(); w++; end
        chk({tag, " latency"}, w, NT + 2);
        chk({tag, " dout"}, $signed(dout1), e);
        tick();
        chk({tag, " pulse"}, {vo1, ready1}, 2'b01);
        chk({tag, " hold"}, $signed(dout1), e);
        $display("u1 %s din=%0d dout=%0d exp=%0d lat=%0d", tag, $signed(s), $signed(dout1), e, w);
    endtask

    initial begin
        rst1 = 1'b0; rst4 = 1'b0;
        valid1 = 1'b0; valid4 = 1'b0; validr = 1'b0;
        din1 = '0; din4 = '0; dinr = '0;
        repeat (3) tick();
        chk("reset ready1", ready1, 0);
        chk("reset ready4", ready4, 0);
        chk("reset valid_out", {vo1, vo4, vor}, 0);
        chk("reset dout", dout1, 0);
        chk("reset phase", u4.phase_q, 0);
        rst1 = 1'b1; rst4 = 1'b1;
        tick();
        chk("ready after reset", ready1, 1);
        $display("reset released");

        // Impulse through DECIM=1: coefficients read back scaled by -32768.
        send1(16'h8000, "imp0");
        chk("imp first", $signed(dout1), -262144);
        for (int k = 1; k <= NT + 1; k++) begin
            send1(16'h0000, $sformatf("imp%0d", k));
            if (k == 18) chk("imp centre", $signed(dout1), -4161536);
            if (k == NT) chk("imp tail", $signed(dout1), 0);
        end

        // Random history across three wraps of the write pointer.
        for (int i = 0; i < 3 * NT; i++) begin
            send1(16'($urandom_range(0, 65535)), $sformatf("wrap%0d", i));
        end

        // Trigger, then reset 10 cycles in with valid_in high: abort, nothing captured.
        n = 0;
        while (!ready1 && n < 100) begin tick(); n++; end
        valid1 = 1'b1;
        din1 = 16'h7fff;
        tick();
        valid1 = 1'b0;
        repeat (9) tick();
        rst1 = 1'b0;
        valid1 = 1'b1;
        din1 = 16'h1234;
        tick();
        chk("mid reset ready", ready1, 0);
        chk("mid reset valid_out", vo1, 0);
        tick();
        rst1 = 1'b1;
        valid1 = 1'b0;
        seen = 0;
        repeat (60) begin
            tick();
            if (vo1) seen = 1;
        end
        chk("abort no valid_out", seen, 0);
        chk("abort dout cleared", dout1, 0);
        $display("u1 reset mid-MAC done");
        hist1.delete();
        send1(16'h8000, "post_reset");
        chk("post reset first", $signed(dout1), -262144);

        // Step into DECIM=4 with valid_in held high, including while busy.
        valid4 = 1'b1;
        din4 = 16'h8000;
        due = -1; ph = 0; outs = 0; last4 = 0; exp4 = 0;
        for (int cyc = 0; cyc < 700 && outs < 12; cyc++) begin
            exp_rdy = (due < 0);
            chk("step ready", ready4, exp_rdy);
            chk("step valid_out", vo4, cyc == due);
            if (cyc == due) begin
                chk("step dout", $signed(dout4), exp4);
                last4 = $signed(dout4);
                outs++;
                due = -1;
                $display("u4 out%0d dout=%0d exp=%0d", outs, $signed(dout4), exp4);
            end
            if (exp_rdy) begin
                chk("step phase", u4.phase_q, ph);
                hist4.push_back(-32768);
                if (ph == 3) begin
                    ph = 0;
                    due = cyc + NT + 3;
                    exp4 = ref_out(hist4);
                end else begin
                    ph++;
                end
            end
            tick();
        end
        valid4 = 1'b0;
        chk("step outputs", outs, 12);
        chk("step settled", last4, -16875520);

        // Rounding variant: acc=6 with two fractional bits.
        n = 0;
        while (!readyr && n < 100) begin tick(); n++; end
        validr = 1'b1;
        dinr = 16'd1;
        tick();
        validr = 1'b0;
        n = 0;
        while (!vor && n < 100) begin tick(); n++; end
        chk("round latency", n, NT + 2);
        chk("round dout", $signed(doutr), ROUND_EXP);
        $display("ur din=1 dout=%0d exp=%0d", $signed(doutr), ROUND_EXP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
